// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug) round-robin arbiter in front of a single-ported data memory.
// Fixed three-cycle transaction: grant in IDLE, memory access in ACCESS, ack pulse in RESP.
module mem_arbiter #(
  parameter int unsigned MAX_MEM_INDEX = 127
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,

  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,

  output logic        err,
  output logic        busy,

  output logic        mwr,
  output logic        moe,
  output logic [31:0] ma,
  output logic [31:0] mwd,
  input  logic [31:0] mrd
);

  // state  | meaning
  // IDLE   | waiting for a request; arbitrates and latches the winner
  // ACCESS | memory driven with latched request; read data captured
  // RESP   | one-cycle ack (and err) to the owning port

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  state_t      state;
  logic        rr_ptr;
  logic        owner;
  logic        we_q;
  logic        fault_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        grant_dbg;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} > MAX_MEM_INDEX);
  endfunction

  // Contention goes to the port named by rr_ptr; a lone requester always wins.
  always_comb begin
    grant_dbg = dbg_req;
    if (cpu_req && dbg_req) begin
      grant_dbg = rr_ptr;
    end
    sel_we    = grant_dbg ? dbg_we    : cpu_we;
    sel_addr  = grant_dbg ? dbg_addr  : cpu_addr;
    sel_wdata = grant_dbg ? dbg_wdata : cpu_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= PORT_CPU;
      owner     <= PORT_CPU;
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      err       <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req || dbg_req) begin
            owner   <= grant_dbg;
            rr_ptr  <= ~grant_dbg;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            fault_q <= is_fault(sel_addr);
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (owner == PORT_DBG) begin
            dbg_rdata <= fault_q ? 32'h0 : mrd;
            dbg_ack   <= 1'b1;
          end else begin
            cpu_rdata <= fault_q ? 32'h0 : mrd;
            cpu_ack   <= 1'b1;
          end
          err   <= fault_q;
          state <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // reset gates the strobe directly so a reset landing mid-ACCESS never writes.
  assign mwr  = (state == ST_ACCESS) && we_q && !fault_q && !reset;
  assign moe  = (state == ST_ACCESS) && !we_q;
  assign ma   = addr_q;
  assign mwd  = wdata_q;
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, contention sequences,
// reset-abort case and a randomized two-port run against a transaction-level model.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        err, busy, mwr, moe;
  logic [31:0] ma, mwd, mrd;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int bad_reset_wr = 0;
  int bad_fault_wr = 0;

  logic        mem_init;
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:127];

  mem_arbiter #(.MAX_MEM_INDEX(127)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .err(err), .busy(busy),
    .mwr(mwr), .moe(moe), .ma(ma), .mwd(mwd), .mrd(mrd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural memory: combinational read, write on the edge ending a strobed cycle.
  assign mrd = mem[ma[9:2]];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (mwr) begin
      mem[ma[9:2]] <= mwd;
    end
  end

  function automatic bit tb_fault(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) > 127);
  endfunction

  always @(negedge clock) begin
    if (mwr === 1'b1 && reset === 1'b1) bad_reset_wr++;
    if (mwr === 1'b1 && tb_fault(ma)) bad_fault_wr++;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
    edge_cnt++;
  endtask

  task automatic set_port(input bit p, input bit req, input bit we,
                          input logic [31:0] a, input logic [31:0] d);
    if (!p) begin
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end else begin
      dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    end
  endtask

  task automatic do_reset(input bit init);
    reset = 1'b1;
    mem_init = init;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    tick;
    tick;
    reset = 1'b0;
    mem_init = 1'b0;
  endtask

  // Single-port transaction; reports what was seen so the caller can compare.
  task automatic do_txn(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic e, output logic [31:0] rd,
                        output logic other, output logic wr_acc, output logic oe_acc,
                        output logic busy_acc);
    lat = -1; e = 1'b0; rd = '0; other = 1'b0; wr_acc = 1'b0; oe_acc = 1'b0; busy_acc = 1'b0;
    set_port(p, 1, we, a, d);
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      tick;
      if (k == 1) begin
        wr_acc = mwr; oe_acc = moe; busy_acc = busy;
      end
      if ((p ? cpu_ack : dbg_ack) === 1'b1) other = 1'b1;
      if ((p ? dbg_ack : cpu_ack) === 1'b1) begin
        lat = k; e = err; rd = p ? dbg_rdata : cpu_rdata;
      end
    end
    set_port(p, 0, we, a, d);
    tick;
  endtask

  task automatic race(output int cpu_e, output int dbg_e);
    cpu_e = -1; dbg_e = -1;
    set_port(0, 1, 0, 32'h10, 0);
    set_port(1, 1, 0, 32'h1FC, 0);
    for (int k = 0; k < 12 && (cpu_e < 0 || dbg_e < 0); k++) begin
      tick;
      if (cpu_ack === 1'b1 && cpu_e < 0) begin cpu_e = edge_cnt; cpu_req = 1'b0; end
      if (dbg_ack === 1'b1 && dbg_e < 0) begin dbg_e = edge_cnt; dbg_req = 1'b0; end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  bit          pend [2];
  logic        we_r [2];
  logic [31:0] addr_r [2];
  logic [31:0] wdata_r [2];

  initial begin
    vec_t        vecs [12];
    int          lat, ce, de, start, nacks, last_e;
    logic        e, other, wr_acc, oe_acc, busy_acc, last_p, rq0, rq1, win, f, exp0, exp1;
    logic [31:0] rd, m_rd;
    int          free_edge, m_ack_edge;
    logic        m_valid, m_port, m_err, m_rr;
    int          r;
    logic [31:0] na;

    vecs[0]  = '{0, 1, 32'h10,  32'hDEADBEEF, 0, 32'hA500_0004};
    vecs[1]  = '{0, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF};
    vecs[2]  = '{1, 1, 32'h200, 32'h12345678, 1, 32'h0};
    vecs[3]  = '{1, 0, 32'h200, 32'h0,        1, 32'h0};
    vecs[4]  = '{0, 1, 32'h13,  32'hBAD0BAD0, 1, 32'h0};
    vecs[5]  = '{0, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF};
    vecs[6]  = '{1, 1, 32'h1FC, 32'hCAFEF00D, 0, 32'hA500_007F};
    vecs[7]  = '{1, 0, 32'h1FC, 32'h0,        0, 32'hCAFEF00D};
    vecs[8]  = '{0, 0, 32'h1FC, 32'h0,        0, 32'hCAFEF00D};
    vecs[9]  = '{1, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF};
    vecs[10] = '{0, 0, 32'h2,   32'h0,        1, 32'h0};
    vecs[11] = '{1, 0, 32'h0,   32'h0,        0, 32'hA500_0000};

    reset = 1'b1;
    mem_init = 1'b0;
    do_reset(1);

    chk1("rst_cpu_ack", cpu_ack, 1'b0);
    chk1("rst_dbg_ack", dbg_ack, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mwr", mwr, 1'b0);
    chk1("rst_moe", moe, 1'b0);
    chk32("rst_ma", ma, 32'h0);
    chk32("rst_mwd", mwd, 32'h0);
    chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk32("rst_dbg_rdata", dbg_rdata, 32'h0);

    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             lat, e, rd, other, wr_acc, oe_acc, busy_acc);
      chk_int($sformatf("vec%0d_latency", i), lat, 2);
      chk1($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      chk32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk1($sformatf("vec%0d_other_ack", i), other, 1'b0);
      chk1($sformatf("vec%0d_mwr_access", i), wr_acc, vecs[i].we && !vecs[i].exp_err);
      chk1($sformatf("vec%0d_moe_access", i), oe_acc, !vecs[i].we);
      chk1($sformatf("vec%0d_busy_access", i), busy_acc, 1'b1);
      chk1($sformatf("vec%0d_ack_one_cycle", i), vecs[i].port ? dbg_ack : cpu_ack, 1'b0);
      chk1($sformatf("vec%0d_busy_after", i), busy, 1'b0);
      chk32($sformatf("vec%0d_rdata_hold", i),
            vecs[i].port ? dbg_rdata : cpu_rdata, vecs[i].exp_rdata);
    end
    chk32("store_0x13_word_0x10_intact", mem[4], 32'hDEADBEEF);

    // Simultaneous requests straight after reset: CPU first, then DBG.
    do_reset(0);
    start = edge_cnt;
    race(ce, de);
    chk_int("race1_cpu_ack_edge", ce, start + 2);
    chk_int("race1_dbg_ack_edge", de, ce + 3);
    // A lone CPU grant leaves the pointer on DBG, so DBG wins the next tie.
    do_txn(0, 0, 32'h10, 0, lat, e, rd, other, wr_acc, oe_acc, busy_acc);
    chk_int("lone_cpu_latency", lat, 2);
    start = edge_cnt;
    race(ce, de);
    chk_int("race2_dbg_ack_edge", de, start + 2);
    chk_int("race2_cpu_ack_edge", ce, de + 3);

    // Both ports held continuously: strict alternation, one ack every 3 cycles.
    set_port(0, 1, 0, 32'h10, 0);
    set_port(1, 1, 0, 32'h1FC, 0);
    nacks = 0; last_e = 0; last_p = 1'b0;
    for (int k = 0; k < 80 && nacks < 20; k++) begin
      tick;
      if (cpu_ack === 1'b1 && dbg_ack === 1'b1) chk1("held_dual_ack", 1'b1, 1'b0);
      if (cpu_ack === 1'b1 || dbg_ack === 1'b1) begin
        if (nacks > 0) begin
          chk1($sformatf("held_alt%0d", nacks), dbg_ack, !last_p);
          chk_int($sformatf("held_gap%0d", nacks), edge_cnt - last_e, 3);
        end
        last_p = dbg_ack; last_e = edge_cnt; nacks++;
      end
    end
    chk_int("held_ack_count", nacks, 20);
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    tick;

    // Reset landing while a store is in ACCESS.
    set_port(0, 1, 1, 32'h20, 32'h11111111);
    tick;
    chk1("abort_mwr_live", mwr, 1'b1);
    reset = 1'b1;
    #1;
    chk1("abort_mwr_in_reset", mwr, 1'b0);
    cpu_req = 1'b0;
    tick;
    chk1("abort_no_ack", cpu_ack, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    reset = 1'b0;
    tick;
    chk1("abort_no_ack_late", cpu_ack, 1'b0);
    chk32("abort_word_unchanged", mem[8], 32'hA500_0008);

    // Randomized two-port traffic against a transaction-level model.
    do_reset(1);
    for (int i = 0; i < 128; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; we_r[p] = 1'b0; addr_r[p] = '0; wdata_r[p] = '0;
    end
    free_edge = edge_cnt + 1;
    m_valid = 1'b0; m_port = 1'b0; m_err = 1'b0; m_rd = '0; m_ack_edge = 0; m_rr = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rq0 = cpu_req; rq1 = dbg_req;
      tick;
      if (edge_cnt >= free_edge && (rq0 || rq1)) begin
        win = (rq0 && rq1) ? m_rr : rq1;
        m_rr = !win;
        f = tb_fault(addr_r[win]);
        m_rd = f ? 32'h0 : ref_mem[7'(addr_r[win] / 4)];
        if (!f && we_r[win]) ref_mem[7'(addr_r[win] / 4)] = wdata_r[win];
        m_err = f; m_port = win; m_valid = 1'b1;
        m_ack_edge = edge_cnt + 1;
        free_edge = edge_cnt + 3;
      end
      exp0 = m_valid && (m_ack_edge == edge_cnt) && !m_port;
      exp1 = m_valid && (m_ack_edge == edge_cnt) && m_port;
      chk1("rnd_cpu_ack", cpu_ack, exp0);
      chk1("rnd_dbg_ack", dbg_ack, exp1);
      if (exp0 || exp1) begin
        chk1("rnd_err", err, m_err);
        chk32("rnd_rdata", m_port ? dbg_rdata : cpu_rdata, m_rd);
      end
      for (int p = 0; p < 2; p++) begin
        if ((p == 0 && exp0) || (p == 1 && exp1)) begin
          pend[p] = 1'b0;
          set_port(p[0], 0, we_r[p], addr_r[p], wdata_r[p]);
        end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 9);
          if (r <= 6)      na = 32'($urandom_range(0, 127)) * 4;
          else if (r == 7) na = 32'($urandom_range(0, 127)) * 4 + 32'($urandom_range(1, 3));
          else if (r == 8) na = 32'($urandom_range(128, 255)) * 4;
          else             na = 32'h10;
          pend[p] = 1'b1;
          we_r[p] = 1'($urandom_range(0, 1));
          addr_r[p] = na;
          wdata_r[p] = $urandom;
          set_port(p[0], 1, we_r[p], addr_r[p], wdata_r[p]);
        end
      end
    end
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    tick; tick; tick;

    chk_int("mwr_during_reset", bad_reset_wr, 0);
    chk_int("mwr_on_fault", bad_fault_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_MEM_INDEX, default 127, highest legal word index (matches data-memory depth).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-003 clock  input  1  sole clock; all state changes on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU data-port request; held high until cpu_ack.
REQ-006 cpu_we  input  1  CPU write enable (1=store, 0=load); stable while cpu_req high.
REQ-007 cpu_addr  input  32  CPU byte address.
REQ-008 cpu_wdata  input  32  CPU store data.
REQ-009 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-010 cpu_rdata  output  32  CPU load data; valid while cpu_ack high.
REQ-011 dbg_req  input  1  debug/loader request; held high until dbg_ack.
REQ-012 dbg_we  input  1  debug write enable.
REQ-013 dbg_addr  input  32  debug byte address.
REQ-014 dbg_wdata  input  32  debug store data.
REQ-015 dbg_ack  output  1  one-cycle completion pulse to debug port.
REQ-016 dbg_rdata  output  32  debug load data; valid while dbg_ack high.
REQ-017 err  output  1  access fault flag; valid only with cpu_ack or dbg_ack.
REQ-018 busy  output  1  high when state is not IDLE.
REQ-019 mwr  output  1  memory write strobe.
REQ-020 moe  output  1  memory output enable.
REQ-021 ma  output  32  memory byte address.
REQ-022 mwd  output  32  memory write data.
REQ-023 mrd  input  32  memory read data (combinational from ma).

Function
REQ-024 The FSM SHALL have states IDLE, ACCESS, RESP.
REQ-025 IDLE: no request -> stay IDLE; otherwise pick owner, latch owner's we/addr/wdata into internal registers, go ACCESS.
REQ-026 Arbitration SHALL be round-robin: single request wins outright; both requesting -> port named by rr_ptr wins; after any grant rr_ptr points to the other port.
REQ-027 ACCESS: drive ma=latched addr, mwd=latched wdata, mwr=latched we AND NOT fault, moe=NOT latched we; capture mrd into rdata register; go RESP.
REQ-028 Outside ACCESS, mwr and moe SHALL be 0; ma and mwd SHALL hold latched values.
REQ-029 Fault SHALL be: addr[1:0] != 0, or (addr >> 2) > MAX_MEM_INDEX; a faulting access SHALL NOT write memory and SHALL return rdata=0.
REQ-030 RESP: pulse owner's ack for exactly one cycle, err=fault; go IDLE.
REQ-031 Owner's rdata output SHALL show captured data during ack; non-owner ack SHALL stay 0; rdata outputs SHALL hold their last value otherwise.
REQ-032 Latency SHALL be fixed: request sampled in IDLE at edge N -> ack high in cycle N+2 -> next grant earliest at edge N+3.
REQ-033 Requesters drop req at the edge where ack is sampled high; a req still high in IDLE after RESP SHALL be treated as a new request.
REQ-034 Request changes during ACCESS/RESP SHALL NOT affect the in-flight access (latched values only).
REQ-035 A waiting requester SHALL be granted within one in-flight transaction (no starvation).

Reset
REQ-036 With reset high at an edge: state=IDLE, rr_ptr=CPU, latched addr/wdata/we=0, rdata registers=0, cpu_ack=dbg_ack=err=busy=0.
REQ-037 mwr SHALL be 0 in any cycle where reset is high, including reset asserted mid-ACCESS; the in-flight access SHALL be dropped with no ack.

Verification
REQ-038 CPU store addr 0x10 data 0xDEADBEEF, then CPU load 0x10 -> store ack at cycle+2 with err=0; load cpu_rdata=0xDEADBEEF.
REQ-039 cpu_req and dbg_req raised same cycle after reset -> CPU acked first, DBG acked 3 cycles later; repeat -> DBG first.
REQ-040 dbg store addr 0x200 (index 128) -> dbg_ack with err=1, mwr never high, load of 0x200 returns 0 with err=1.
REQ-041 CPU store addr 0x13 -> err=1, no write; word at 0x10 unchanged.
REQ-042 Reset asserted during ACCESS of a store -> mwr=0 that cycle, no ack, busy=0 next cycle, memory word unchanged.
REQ-043 Both ports held requesting continuously for 20 transactions -> acks strictly alternate CPU/DBG, one ack per 3 cycles.
